// File: rtl/systolic_feeder_32x32.sv
// Upstream sequencer for the output-stationary systolic array: accepts one K-step per
// beat, applies the triangular input skew and drives en/clear_acc/done for the array.
module systolic_feeder_32x32 #(
   parameter int ARRAY_SIZE = 32,
   parameter int DATA_WIDTH = 16,
   parameter int K_WIDTH    = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [K_WIDTH-1:0]               k_len,
   output logic                             busy,
   output logic                             done,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_a,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_b,
   output logic [DATA_WIDTH-1:0]            a_col [ARRAY_SIZE],
   output logic [DATA_WIDTH-1:0]            b_row [ARRAY_SIZE],
   output logic                             en,
   output logic                             clear_acc,
   output logic [1:0]                       dbg_state
);

   // Handshake: a beat transfers on a rising edge where in_valid && in_ready are both
   // high; in_ready is high only in FEED and does not depend on in_valid.

   localparam int CNT_W = $clog2(2*ARRAY_SIZE);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2*ARRAY_SIZE-2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_FEED  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t             state, state_n;
   logic [K_WIDTH-1:0] k_reg;
   logic [K_WIDTH-1:0] beat_cnt;
   logic [CNT_W-1:0]   drain_cnt;
   logic               accept;
   logic               last_drain;

   assign dbg_state = state;
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         k_reg     <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
         done      <= 1'b0;
      end else begin
         state <= state_n;
         done  <= last_drain;
         if (state == S_IDLE && start)
            k_reg <= k_len;
         if (state == S_CLEAR) begin
            beat_cnt  <= '0;
            drain_cnt <= '0;
         end
         if (accept)
            beat_cnt <= beat_cnt + K_WIDTH'(1);
         if (state == S_DRAIN)
            drain_cnt <= drain_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_n    = state;
      en         = 1'b0;
      clear_acc  = 1'b0;
      in_ready   = 1'b0;
      accept     = 1'b0;
      last_drain = 1'b0;
      case (state)
         S_IDLE: begin
            if (start)
               state_n = S_CLEAR;
         end
         S_CLEAR: begin
            en        = 1'b1;
            clear_acc = 1'b1;
            state_n   = (k_reg == '0) ? S_DRAIN : S_FEED;
         end
         S_FEED: begin
            en       = 1'b1;
            in_ready = 1'b1;
            accept   = in_valid;
            // k_reg >= 1 here, so k_reg-1 cannot underflow
            if (in_valid && beat_cnt == k_reg - K_WIDTH'(1))
               state_n = S_DRAIN;
         end
         S_DRAIN: begin
            en = 1'b1;
            if (drain_cnt == DRAIN_LAST) begin
               last_drain = 1'b1;
               state_n    = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Lane j owns j+1 registers; stage 0 takes the accepted beat or a zero bubble.
   for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
      logic [DATA_WIDTH-1:0] sa [j+1];
      logic [DATA_WIDTH-1:0] sb [j+1];

      always_ff @(posedge clk) begin
         if (rst || clear_acc) begin
            for (int k = 0; k <= j; k++) begin
               sa[k] <= '0;
               sb[k] <= '0;
            end
         end else if (en) begin
            sa[0] <= accept ? in_a[j*DATA_WIDTH +: DATA_WIDTH] : '0;
            sb[0] <= accept ? in_b[j*DATA_WIDTH +: DATA_WIDTH] : '0;
            for (int k = 1; k <= j; k++) begin
               sa[k] <= sa[k-1];
               sb[k] <= sb[k-1];
            end
         end
      end

      assign a_col[j] = sa[j];
      assign b_row[j] = sb[j];
   end

endmodule

// File: tb/tb_systolic_feeder_32x32.sv
// Bench for systolic_feeder_32x32 at ARRAY_SIZE=4: phase/stream reference model plus a
// behavioural output-stationary array whose accumulators are compared at every done.
module tb_systolic_feeder_32x32;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int KW = 16;
   localparam int P_IDLE = 0, P_CLEAR = 1, P_FEED = 2, P_DRAIN = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            busy, done, in_valid, in_ready, en, clear_acc;
   logic [N*DW-1:0] in_a, in_b;
   logic [DW-1:0]   a_col [N];
   logic [DW-1:0]   b_row [N];
   logic [1:0]      dbg_state;

   systolic_feeder_32x32 #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .K_WIDTH(KW)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .a_col(a_col), .b_row(b_row), .en(en), .clear_acc(clear_acc), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int              m_phase, m_k, m_beats, m_drain;
   bit              m_done;
   logic [N*DW-1:0] sa_q[$], sb_q[$];
   longint          gold [N][N];
   logic [N*DW-1:0] beat_a[$], beat_b[$];

   // attached array model
   longint          acc [N][N];
   logic [DW-1:0]   ar  [N][N];
   logic [DW-1:0]   br  [N][N];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] lane(input logic [N*DW-1:0] v, input int j);
      return v[j*DW +: DW];
   endfunction

   function automatic longint sx(input logic [DW-1:0] x);
      return longint'(signed'(x));
   endfunction

   task automatic fill_zero();
      sa_q.delete();
      sb_q.delete();
      for (int i = 0; i < N; i++) begin
         sa_q.push_back('0);
         sb_q.push_back('0);
      end
   endtask

   task automatic push(input logic [N*DW-1:0] va, input logic [N*DW-1:0] vb);
      sa_q.push_front(va);
      sb_q.push_front(vb);
      void'(sa_q.pop_back());
      void'(sb_q.pop_back());
   endtask

   task automatic model_step();
      m_done = 1'b0;
      if (rst) begin
         m_phase = P_IDLE;
         fill_zero();
      end else begin
         case (m_phase)
            P_IDLE: if (start) begin
               m_k = int'(k_len);
               m_phase = P_CLEAR;
            end
            P_CLEAR: begin
               fill_zero();
               for (int i = 0; i < N; i++)
                  for (int j = 0; j < N; j++) gold[i][j] = 0;
               m_beats = 0;
               m_drain = 0;
               m_phase = (m_k == 0) ? P_DRAIN : P_FEED;
            end
            P_FEED: begin
               if (in_valid) begin
                  push(in_a, in_b);
                  for (int i = 0; i < N; i++)
                     for (int j = 0; j < N; j++)
                        gold[i][j] += sx(lane(in_b, i)) * sx(lane(in_a, j));
                  m_beats++;
                  if (m_beats == m_k) m_phase = P_DRAIN;
               end else begin
                  push('0, '0);
               end
            end
            default: begin
               push('0, '0);
               m_drain++;
               if (m_drain == 2*N-1) begin
                  m_phase = P_IDLE;
                  m_done  = 1'b1;
               end
            end
         endcase
      end
   endtask

   task automatic array_step();
      longint        nacc [N][N];
      logic [DW-1:0] nar  [N][N];
      logic [DW-1:0] nbr  [N][N];
      logic [DW-1:0] ain, bin;
      if (en === 1'b1) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               ain = (i == 0) ? a_col[j] : ar[i-1][j];
               bin = (j == 0) ? b_row[i] : br[i][j-1];
               if (clear_acc === 1'b1) begin
                  nacc[i][j] = 0; nar[i][j] = '0; nbr[i][j] = '0;
               end else begin
                  nacc[i][j] = acc[i][j] + sx(ain) * sx(bin);
                  nar[i][j]  = ain;
                  nbr[i][j]  = bin;
               end
            end
         acc = nacc; ar = nar; br = nbr;
      end
   endtask

   task automatic check_outputs();
      check("busy", 64'(busy), 64'(m_phase != P_IDLE));
      check("in_ready", 64'(in_ready), 64'(m_phase == P_FEED));
      check("en", 64'(en), 64'(m_phase != P_IDLE));
      check("clear_acc", 64'(clear_acc), 64'(m_phase == P_CLEAR));
      check("done", 64'(done), 64'(m_done));
      for (int j = 0; j < N; j++) begin
         check($sformatf("a_col[%0d]", j), 64'(a_col[j]), 64'(lane(sa_q[j], j)));
         check($sformatf("b_row[%0d]", j), 64'(b_row[j]), 64'(lane(sb_q[j], j)));
      end
      if (m_done)
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               check($sformatf("result[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(gold[i][j]));
   endtask

   task automatic tick();
      model_step();
      array_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   // vmode: 0 always valid, 1 alternating 1,0,1,..., 2 random
   task automatic run_job(input int k, input int vmode, input bit noise, input int abort_at);
      int cyc = 0, fcyc = 0;
      int budget = 3*k + 4*N + 20;
      while (beat_a.size() < k) begin
         beat_a.push_back({$urandom, $urandom});
         beat_b.push_back({$urandom, $urandom});
      end
      start = 1'b1; k_len = KW'(k); in_valid = 1'b0;
      tick();
      while (m_phase != P_IDLE && cyc < budget) begin
         if (cyc == abort_at) begin
            rst = 1'b1; start = 1'b0;
            repeat (3) tick();
            rst = 1'b0;
            repeat (3) tick();
            return;
         end
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         k_len = noise ? KW'($urandom_range(0, 9)) : KW'(k);
         in_a  = {$urandom, $urandom};
         in_b  = {$urandom, $urandom};
         if (m_phase == P_FEED) begin
            case (vmode)
               0:       in_valid = 1'b1;
               1:       in_valid = (fcyc % 2 == 0);
               default: in_valid = 1'($urandom_range(0, 1));
            endcase
            fcyc++;
            if (in_valid) begin
               in_a = beat_a[m_beats];
               in_b = beat_b[m_beats];
            end
         end else begin
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         tick();
         cyc++;
      end
      if (m_phase != P_IDLE) check("job_timeout", 64'(m_phase), 64'(P_IDLE));
      start = 1'b0; in_valid = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            acc[i][j] = 0; ar[i][j] = '0; br[i][j] = '0; gold[i][j] = 0;
         end
      m_phase = P_IDLE; m_k = 0; m_beats = 0; m_drain = 0; m_done = 1'b0;
      fill_zero();
      rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      // reset held 3 cycles mid-FEED aborts the job
      run_job(4, 0, 1'b0, 3);
      beat_a.delete(); beat_b.delete();

      // single beat, a lanes 1..4, b all ones
      beat_a.push_back({16'd4, 16'd3, 16'd2, 16'd1});
      beat_b.push_back({16'd1, 16'd1, 16'd1, 16'd1});
      run_job(1, 0, 1'b0, -1);
      beat_a.delete(); beat_b.delete();

      // random signed product, then the same data under backpressure
      run_job(4, 0, 1'b0, -1);
      run_job(4, 1, 1'b0, -1);
      beat_a.delete(); beat_b.delete();

      // empty job
      run_job(0, 0, 1'b0, -1);

      // start/k_len/in_valid noise outside their windows, then a clean job
      run_job(5, 2, 1'b1, -1);
      beat_a.delete(); beat_b.delete();
      run_job(3, 0, 1'b0, -1);
      beat_a.delete(); beat_b.delete();

      for (int r = 0; r < 6; r++) begin
         run_job($urandom_range(1, 9), 2, 1'($urandom_range(0, 1)), -1);
         beat_a.delete(); beat_b.delete();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
